// File: rtl/dmb_trig_pkg.sv
// Shared constants and window-mask helper for the DMB pre-LCT / L1A trigger path.
package dmb_trig_pkg;

    localparam int unsigned NCFEB = 5;
    localparam int unsigned DLY_W = 8;
    localparam int unsigned WIN_W = 4;
    localparam int unsigned DEPTH = (1 << DLY_W) + (1 << WIN_W);

    typedef logic [DEPTH-1:0] hist_t;

    // Window covers history indices dly-1 .. dly-2+win; dly=0 and win=0 both act as 1.
    // Indices at or beyond DEPTH simply have no bit, so they read as 0.
    function automatic hist_t win_mask(input logic [DLY_W-1:0] dly, input logic [WIN_W-1:0] win);
        hist_t       m;
        int unsigned d;
        int unsigned w;
        d = (dly == '0) ? 32'd1 : 32'(dly);
        w = (win == '0) ? 32'd1 : 32'(win);
        m = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            m[j] = ((j + 32'd1) >= d) && ((j + 32'd1) < (d + w));
        end
        return m;
    endfunction

endpackage

// File: rtl/lct_hist_chan.sv
// One CFEB's pre-LCT history: shift register, window OR, slot-0 tap and consume-on-match.
module lct_hist_chan
    import dmb_trig_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  resync,
    input  logic  consume,
    input  logic  lct,
    input  hist_t win,
    input  hist_t slot0,
    output logic  match_c,
    output logic  win0_c
);

    hist_t hist;
    hist_t kill;

    always_comb begin
        kill    = consume ? win : '0;
        match_c = |(hist & win);
        win0_c  = |(hist & slot0);
    end

    // Matched window bits are zeroed as they move up one slot so no LCT matches twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (resync) begin
            hist <= '0;
        end else begin
            hist <= {hist[DEPTH-2:0] & ~kill[DEPTH-2:0], lct};
        end
    end

endmodule

// File: rtl/lct_l1a_match.sv
// Per-CFEB pre-LCT / L1A matching stage feeding the CFEB trigger encoder.
module lct_l1a_match
    import dmb_trig_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             RESYNC,
    input  logic [NCFEB:1]   LCT_IN,
    input  logic             L1A,
    input  logic [DLY_W-1:0] L1A_DLY,
    input  logic [WIN_W-1:0] WIN_SIZE,
    input  logic             SND_WIN,
    output logic [NCFEB:1]   PRE_LCT_OUT,
    output logic             L1ACFEB,
    output logic [NCFEB:1]   L1A_MATCH,
    output logic [NCFEB:1]   MTCH_WIN_0,
    output logic             L1A_NOMATCH,
    output logic             RESYNC_RST
);

    hist_t          win_q;
    hist_t          slot0_q;
    logic           accept_c;
    logic [NCFEB:1] match_c;
    logic [NCFEB:1] win0_c;

    assign accept_c = L1A & ~RESYNC;

    // Latency and window are static, so the decoded masks are registered off the timing path.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            win_q   <= '0;
            slot0_q <= '0;
        end else begin
            win_q   <= win_mask(L1A_DLY, WIN_SIZE);
            slot0_q <= win_mask(L1A_DLY, WIN_W'(1));
        end
    end

    for (genvar i = 1; i <= NCFEB; i++) begin : g_chan
        lct_hist_chan u_chan (
            .clk     (CLK),
            .rst_n   (RST_N),
            .resync  (RESYNC),
            .consume (accept_c),
            .lct     (LCT_IN[i]),
            .win     (win_q),
            .slot0   (slot0_q),
            .match_c (match_c[i]),
            .win0_c  (win0_c[i])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PRE_LCT_OUT <= '0;
            L1ACFEB     <= 1'b0;
            L1A_MATCH   <= '0;
            MTCH_WIN_0  <= '0;
            L1A_NOMATCH <= 1'b0;
            RESYNC_RST  <= 1'b0;
        end else begin
            PRE_LCT_OUT <= LCT_IN;
            L1ACFEB     <= accept_c;
            L1A_MATCH   <= accept_c ? match_c : '0;
            MTCH_WIN_0  <= (accept_c && SND_WIN) ? win0_c : '0;
            L1A_NOMATCH <= accept_c && (match_c == '0);
            RESYNC_RST  <= RESYNC;
        end
    end

endmodule

// File: tb/tb_lct_l1a_match.sv
// Directed self-checking bench for lct_l1a_match.
module tb_lct_l1a_match;
    import dmb_trig_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             resync;
    logic [NCFEB:1]   lct_in;
    logic             l1a;
    logic [DLY_W-1:0] l1a_dly;
    logic [WIN_W-1:0] win_size;
    logic             snd_win;
    logic [NCFEB:1]   pre_lct_out;
    logic             l1acfeb;
    logic [NCFEB:1]   l1a_match;
    logic [NCFEB:1]   mtch_win_0;
    logic             l1a_nomatch;
    logic             resync_rst;

    int n_checks = 0;
    int n_fail   = 0;

    lct_l1a_match dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .RESYNC      (resync),
        .LCT_IN      (lct_in),
        .L1A         (l1a),
        .L1A_DLY     (l1a_dly),
        .WIN_SIZE    (win_size),
        .SND_WIN     (snd_win),
        .PRE_LCT_OUT (pre_lct_out),
        .L1ACFEB     (l1acfeb),
        .L1A_MATCH   (l1a_match),
        .MTCH_WIN_0  (mtch_win_0),
        .L1A_NOMATCH (l1a_nomatch),
        .RESYNC_RST  (resync_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic [NCFEB:1] lct, input logic a, input logic rs);
        lct_in = lct;
        l1a    = a;
        resync = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({pre_lct_out, l1acfeb, l1a_match, mtch_win_0, l1a_nomatch, resync_rst} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 0",
                     {pre_lct_out, l1acfeb, l1a_match, mtch_win_0, l1a_nomatch, resync_rst});
        end
        rst_n = 1'b1;
        idle(2);
        n_checks++;
        if (l1acfeb !== 1'b0 || l1a_nomatch !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got l1acfeb=%b nomatch=%b want 0 0", l1acfeb, l1a_nomatch);
        end
    endtask

    task automatic test_slot0();
        flush();
        cyc(5'b00010, 1'b0, 1'b0);
        idle(9);
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1acfeb !== 1'b1) begin
            n_fail++; $display("FAIL slot0_l1acfeb got %b want 1", l1acfeb);
        end
        n_checks++;
        if (l1a_match !== 5'b00010) begin
            n_fail++; $display("FAIL slot0_match got %b want 00010", l1a_match);
        end
        n_checks++;
        if (mtch_win_0 !== 5'b00010) begin
            n_fail++; $display("FAIL slot0_win0 got %b want 00010", mtch_win_0);
        end
        n_checks++;
        if (l1a_nomatch !== 1'b0) begin
            n_fail++; $display("FAIL slot0_nomatch got %b want 0", l1a_nomatch);
        end
        idle(1);
        n_checks++;
        if (l1acfeb !== 1'b0 || l1a_match !== 5'b00000) begin
            n_fail++;
            $display("FAIL slot0_one_clock got l1acfeb=%b match=%b want 0 00000", l1acfeb, l1a_match);
        end
    endtask

    task automatic test_window_edges();
        // LCT in slot 2 (last slot of a 3-wide window)
        flush();
        cyc(5'b00010, 1'b0, 1'b0);
        idle(11);
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1a_match !== 5'b00010 || mtch_win_0 !== 5'b00000) begin
            n_fail++;
            $display("FAIL slot2 got match=%b win0=%b want 00010 00000", l1a_match, mtch_win_0);
        end
        // One clock past the window
        flush();
        cyc(5'b00010, 1'b0, 1'b0);
        idle(12);
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1a_match !== 5'b00000 || l1a_nomatch !== 1'b1) begin
            n_fail++;
            $display("FAIL past_window got match=%b nomatch=%b want 00000 1", l1a_match, l1a_nomatch);
        end
        // One clock too early (index 8)
        flush();
        cyc(5'b00010, 1'b0, 1'b0);
        idle(8);
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1a_match !== 5'b00000 || l1a_nomatch !== 1'b1) begin
            n_fail++;
            $display("FAIL before_window got match=%b nomatch=%b want 00000 1", l1a_match, l1a_nomatch);
        end
        // SND_WIN low masks slot-0 output but not the match
        snd_win = 1'b0;
        flush();
        cyc(5'b10000, 1'b0, 1'b0);
        idle(9);
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1a_match !== 5'b10000 || mtch_win_0 !== 5'b00000) begin
            n_fail++;
            $display("FAIL snd_win_off got match=%b win0=%b want 10000 00000", l1a_match, mtch_win_0);
        end
        snd_win = 1'b1;
    endtask

    task automatic test_back_to_back();
        flush();
        cyc(5'b01000, 1'b0, 1'b0);
        idle(9);
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1a_match !== 5'b01000) begin
            n_fail++; $display("FAIL b2b_first got %b want 01000", l1a_match);
        end
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1a_match !== 5'b00000 || l1a_nomatch !== 1'b1 || l1acfeb !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_consumed got match=%b nomatch=%b l1acfeb=%b want 00000 1 1",
                     l1a_match, l1a_nomatch, l1acfeb);
        end
        // CFEB1 at A, CFEB3 at A+1: first L1A takes CFEB1, second takes CFEB3 only
        flush();
        cyc(5'b00001, 1'b0, 1'b0);
        cyc(5'b00100, 1'b0, 1'b0);
        idle(8);
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1a_match !== 5'b00001) begin
            n_fail++; $display("FAIL b2b_mixed_first got %b want 00001", l1a_match);
        end
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1a_match !== 5'b00100 || l1a_nomatch !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_mixed_second got match=%b nomatch=%b want 00100 0", l1a_match, l1a_nomatch);
        end
    endtask

    task automatic test_resync();
        flush();
        cyc(5'b11111, 1'b0, 1'b0);
        idle(4);
        cyc(5'b01010, 1'b0, 1'b1);
        n_checks++;
        if (resync_rst !== 1'b1 || pre_lct_out !== 5'b01010) begin
            n_fail++;
            $display("FAIL resync_rst got rst=%b pre=%b want 1 01010", resync_rst, pre_lct_out);
        end
        idle(1);
        n_checks++;
        if (resync_rst !== 1'b0) begin
            n_fail++; $display("FAIL resync_one_clock got %b want 0", resync_rst);
        end
        idle(3);
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1a_match !== 5'b00000 || l1a_nomatch !== 1'b1) begin
            n_fail++;
            $display("FAIL resync_cleared got match=%b nomatch=%b want 00000 1", l1a_match, l1a_nomatch);
        end
        // L1A together with RESYNC is suppressed
        flush();
        cyc(5'b00001, 1'b0, 1'b0);
        idle(9);
        cyc(5'b10101, 1'b1, 1'b1);
        n_checks++;
        if (l1acfeb !== 1'b0 || l1a_nomatch !== 1'b0 || l1a_match !== 5'b00000 || mtch_win_0 !== 5'b00000) begin
            n_fail++;
            $display("FAIL l1a_resync got l1acfeb=%b nomatch=%b match=%b win0=%b want 0 0 00000 00000",
                     l1acfeb, l1a_nomatch, l1a_match, mtch_win_0);
        end
        n_checks++;
        if (resync_rst !== 1'b1 || pre_lct_out !== 5'b10101) begin
            n_fail++;
            $display("FAIL l1a_resync_rst got rst=%b pre=%b want 1 10101", resync_rst, pre_lct_out);
        end
    endtask

    task automatic test_async_reset();
        flush();
        cyc(5'b00001, 1'b0, 1'b0);
        idle(3);
        cyc(5'b11110, 1'b1, 1'b0);
        n_checks++;
        if (pre_lct_out !== 5'b11110 || l1acfeb !== 1'b1 || l1a_nomatch !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset got pre=%b l1acfeb=%b nomatch=%b want 11110 1 1",
                     pre_lct_out, l1acfeb, l1a_nomatch);
        end
        lct_in = '0;
        l1a    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pre_lct_out, l1acfeb, l1a_match, mtch_win_0, l1a_nomatch, resync_rst} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got %b want 0",
                     {pre_lct_out, l1acfeb, l1a_match, mtch_win_0, l1a_nomatch, resync_rst});
        end
        #1 rst_n = 1'b1;
        idle(5);
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1a_match !== 5'b00000 || l1a_nomatch !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset got match=%b nomatch=%b want 00000 1", l1a_match, l1a_nomatch);
        end
    endtask

    task automatic test_min_config();
        // L1A_DLY=0 acts as 1, WIN_SIZE=0 acts as 1
        l1a_dly  = '0;
        win_size = '0;
        flush();
        cyc(5'b00100, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1a_match !== 5'b00100 || mtch_win_0 !== 5'b00100) begin
            n_fail++;
            $display("FAIL min_cfg_hit got match=%b win0=%b want 00100 00100", l1a_match, mtch_win_0);
        end
        flush();
        cyc(5'b00100, 1'b0, 1'b0);
        idle(1);
        cyc('0, 1'b1, 1'b0);
        n_checks++;
        if (l1a_match !== 5'b00000 || l1a_nomatch !== 1'b1) begin
            n_fail++;
            $display("FAIL min_cfg_miss got match=%b nomatch=%b want 00000 1", l1a_match, l1a_nomatch);
        end
        l1a_dly  = 8'd10;
        win_size = 4'd3;
    endtask

    initial begin
        rst_n    = 1'b0;
        resync   = 1'b0;
        lct_in   = '0;
        l1a      = 1'b0;
        l1a_dly  = 8'd10;
        win_size = 4'd3;
        snd_win  = 1'b1;
        #23;
        test_reset();
        test_slot0();
        test_window_edges();
        test_back_to_back();
        test_resync();
        test_async_reset();
        test_min_config();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
